// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: owns the PC, drives the instruction-memory handshake, redirects on branches.
// Optional feature: define PC_ALIGN_TRAP_EN to trap misaligned branch targets to TRAP_VECTOR.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        trap
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] pend_instr_q, pend_instr_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        trap_q, trap_d;

    logic        consume;
    logic        slot_free;
    logic        redirect_trap;
    logic [31:0] redirect_pc;

`ifdef PC_ALIGN_TRAP_EN
    assign redirect_trap = (br_target[1:0] != 2'b00);
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^br_target[1:0];
    assign redirect_trap      = 1'b0;
`endif
    assign redirect_pc = redirect_trap ? TRAP_VECTOR : {br_target[31:2], 2'b00};

    assign consume   = instr_valid_q && !stall;
    assign slot_free = !instr_valid_q || consume;

    // NOTE: every variable gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q && !consume;
        pend_instr_d  = pend_instr_q;
        pend_pc_d     = pend_pc_q;
        trap_d        = 1'b0;

        if (br_taken) begin
            pc_d          = redirect_pc;
            instr_valid_d = 1'b0;
            trap_d        = redirect_trap;
            // An un-acked request must finish at its original address before fetching the target.
            if (state_q == REQ && !imem_ack) begin
                pend_pc_d = pc_q;
                state_d   = DRAIN;
            end else if (state_q == DRAIN && !imem_ack) begin
                state_d = DRAIN;
            end else begin
                state_d = REQ;
            end
        end else begin
            case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ack) begin
                        pc_d = pc_q + 32'd4;
                        if (slot_free) begin
                            instr_d       = imem_rdata;
                            instr_pc_d    = pc_q;
                            instr_valid_d = 1'b1;
                        end else begin
                            pend_instr_d = imem_rdata;
                            pend_pc_d    = pc_q;
                            state_d      = FULL;
                        end
                    end
                end
                FULL: begin
                    if (!stall) begin
                        instr_d       = pend_instr_q;
                        instr_pc_d    = pend_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = REQ;
                    end
                end
                DRAIN: begin
                    if (imem_ack) state_d = REQ;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            instr_q       <= 32'd0;
            instr_pc_q    <= 32'd0;
            instr_valid_q <= 1'b0;
            pend_instr_q  <= 32'd0;
            pend_pc_q     <= 32'd0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            pend_instr_q  <= pend_instr_d;
            pend_pc_q     <= pend_pc_d;
            trap_q        <= trap_d;
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr   = (state_q == DRAIN) ? pend_pc_q : pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign trap        = trap_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: queue-based reference model plus directed literal checks.
// Build with PC_ALIGN_TRAP_EN defined to exercise the misaligned-target trap.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR  = 32'h0000_0010;

    logic        clk;
    logic        rst_n;
    logic        br_taken;
    logic [31:0] br_target;
    logic        stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        trap;

    pc_fetch_ctrl #(
        .RESET_VECTOR(RESET_VECTOR),
        .TRAP_VECTOR (TRAP_VECTOR)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .stall      (stall),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .trap       (trap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a fetch queue (head = presented instruction, at most two entries),
    // a running PC and an optional stale request still owed by memory.
    typedef struct packed {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_drain;
    logic [31:0] m_drain_addr;
    logic        m_trap;
    logic        cmp_en = 1'b0;

    function automatic logic m_req();
        return m_started && (m_drain || m_q.size() < 2);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_drain ? m_drain_addr : m_pc;
    endfunction

    always @(posedge clk) begin
        logic        req_now;
        logic [31:0] addr_now;
        req_now  = m_req();
        addr_now = m_addr();
        m_trap   = 1'b0;
        if (!rst_n) begin
            m_pc      = RESET_VECTOR;
            m_started = 1'b0;
            m_drain   = 1'b0;
            m_q.delete();
            cmp_en    = 1'b1;
        end else if (br_taken) begin
            if (req_now && !imem_ack) begin
                if (!m_drain) m_drain_addr = addr_now;
                m_drain = 1'b1;
            end else begin
                m_drain = 1'b0;
            end
            m_q.delete();
            m_started = 1'b1;
`ifdef PC_ALIGN_TRAP_EN
            if (br_target % 4 != 0) begin
                m_pc   = TRAP_VECTOR;
                m_trap = 1'b1;
            end else begin
                m_pc = br_target;
            end
`else
            m_pc = br_target - (br_target % 4);
`endif
        end else begin
            m_started = 1'b1;
            if (m_q.size() > 0 && !stall) void'(m_q.pop_front());
            if (req_now && imem_ack) begin
                if (m_drain) begin
                    m_drain = 1'b0;
                end else begin
                    m_q.push_back('{w: imem_rdata, a: m_pc});
                    m_pc = m_pc + 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("imem_req", imem_req, m_req());
            check("imem_addr", imem_addr, m_addr());
            check("instr_valid", instr_valid, m_q.size() > 0);
            check("trap", trap, m_trap);
            if (m_q.size() > 0) begin
                check("instr", instr, m_q[0].w);
                check("instr_pc", instr_pc, m_q[0].a);
            end
        end
    end

    int wcnt = 0;

    // Apply inputs for the next rising edge, then return 1 time unit after it.
    task automatic drive(input logic ack, input logic stl, input logic br, input logic [31:0] tgt);
        imem_ack  = ack;
        stall     = stl;
        br_taken  = br;
        br_target = tgt;
        if (ack) begin
            imem_rdata = 32'hC0DE_0000 + 32'(wcnt);
            wcnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        br_taken   = 1'b0;
        br_target  = 32'd0;
        stall      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;

        // Reset held for three edges.
        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("rst_req", imem_req, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", instr_valid, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", instr_pc, 32'd0);

        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("first_req", imem_req, 32'd1);
        check("first_addr", imem_addr, 32'd0);

        // Zero-wait memory: one instruction per cycle.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            check("zw_pc", instr_pc, 32'(4 * k));
            check("zw_instr", instr, 32'hC0DE_0000 + 32'(k));
            check("zw_valid", instr_valid, 32'd1);
        end

        // Two wait cycles per fetch.
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            check("dl_addr0", imem_addr, 32'h10 + 32'(4 * k));
            check("dl_valid0", instr_valid, 32'd0);
            drive(1'b0, 1'b0, 1'b0, 32'd0);
            check("dl_addr1", imem_addr, 32'h10 + 32'(4 * k));
            drive(1'b1, 1'b0, 1'b0, 32'd0);
            check("dl_pc", instr_pc, 32'h10 + 32'(4 * k));
            check("dl_valid", instr_valid, 32'd1);
        end

        // Stall for four cycles with a fetch arriving in the first.
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("st_pre_pc", instr_pc, 32'h1C);
        drive(1'b1, 1'b1, 1'b0, 32'd0);
        check("st_full_req", imem_req, 32'd0);
        check("st_hold_pc", instr_pc, 32'h1C);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 32'd0);
        check("st_held_pc", instr_pc, 32'h1C);
        check("st_held_valid", instr_valid, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("st_pend_pc", instr_pc, 32'h20);
        check("st_resume_addr", imem_addr, 32'h24);

        // Fresh reset, fetch 0 and 4, then redirect while the request at 8 is outstanding.
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("br_pre_addr", imem_addr, 32'h8);
        drive(1'b0, 1'b0, 1'b1, 32'h100);
        check("br_drain_req", imem_req, 32'd1);
        check("br_drain_addr", imem_addr, 32'h8);
        check("br_valid", instr_valid, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("br_drain_addr2", imem_addr, 32'h8);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("br_target_addr", imem_addr, 32'h100);
        check("br_stale_hidden", instr_valid, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("br_first_pc", instr_pc, 32'h100);
        check("br_first_valid", instr_valid, 32'd1);

        // Redirect coinciding with an ack: the ack is dropped.
        drive(1'b1, 1'b0, 1'b1, 32'h200);
        check("bra_valid", instr_valid, 32'd0);
        check("bra_addr", imem_addr, 32'h200);

        // Misaligned target.
        drive(1'b1, 1'b0, 1'b1, 32'h102);
`ifdef PC_ALIGN_TRAP_EN
        check("mis_trap", trap, 32'd1);
        check("mis_addr", imem_addr, 32'h10);
`else
        check("mis_trap", trap, 32'd0);
        check("mis_addr", imem_addr, 32'h100);
`endif
        drive(1'b0, 1'b0, 1'b0, 32'd0);
        check("mis_trap_end", trap, 32'd0);

        // PC wraps past the top of the address space.
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("wrap_zero", instr_pc, 32'h0);

        // Second redirect while draining keeps the drain address.
        drive(1'b0, 1'b0, 1'b1, 32'h300);
        drive(1'b0, 1'b0, 1'b1, 32'h400);
        check("dd_addr", imem_addr, 32'h4);
        drive(1'b1, 1'b0, 1'b0, 32'd0);
        check("dd_target", imem_addr, 32'h400);

        repeat (3) drive(1'b0, 1'b0, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
